// File: rtl/rfphoenix_thread_ready_tracker_pkg.sv
// Shared thread parameters and types for the rfPhoenix issue front end.
// Tid is one bit wider than needed so out-of-range thread ids can be seen.
package rfPhoenixPkg;

    localparam int NTHREADS = 4;
    localparam int TID_W    = 3;

    typedef logic [TID_W-1:0] Tid;

    typedef enum logic [1:0] {
        TS_DISABLED = 2'd0,
        TS_READY    = 2'd1,
        TS_BUSY     = 2'd2,
        TS_DELAY    = 2'd3
    } thread_state_t;

    function automatic logic [3:0] popcnt(input logic [NTHREADS-1:0] m);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NTHREADS; i++)
            c = c + 4'(m[i]);
        return c;
    endfunction

endpackage

// File: rtl/rfphoenix_thread_ready_tracker_thread_state.sv
// Per-thread issue state machine with post-completion stall counter.
// Events arrive pre-decoded; an event illegal in the current state is ignored.
module rfPhoenix_thread_state
    import rfPhoenixPkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_gnt,
    input  logic          i_done,
    input  logic [3:0]    i_dly,
    input  logic          i_flush,
    output thread_state_t o_state,
    output logic          o_nxt_ready
);

    thread_state_t r_state;
    thread_state_t w_nxt_state;
    logic [3:0]    r_cnt;
    logic [3:0]    w_nxt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TS_DISABLED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        if (!i_en) begin
            w_nxt_state = TS_DISABLED;
            w_nxt_cnt   = '0;
        end else begin
            unique case (r_state)
                TS_DISABLED: w_nxt_state = TS_READY;
                TS_READY: begin
                    if (i_gnt)
                        w_nxt_state = TS_BUSY;
                end
                TS_BUSY: begin
                    if (i_flush) begin
                        w_nxt_state = TS_READY;
                        w_nxt_cnt   = '0;
                    end else if (i_done) begin
                        if (i_dly == 4'd0) begin
                            w_nxt_state = TS_READY;
                        end else begin
                            w_nxt_state = TS_DELAY;
                            w_nxt_cnt   = i_dly;
                        end
                    end
                end
                TS_DELAY: begin
                    // Leave on the cycle the counter reads 1 so the stall is exactly dly cycles
                    if (i_flush || r_cnt <= 4'd1) begin
                        w_nxt_state = TS_READY;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt   = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_nxt_state = TS_DISABLED;
                    w_nxt_cnt   = '0;
                end
            endcase
        end
    end

    assign o_state     = r_state;
    assign o_nxt_ready = (w_nxt_state == TS_READY);

endmodule

// File: rtl/rfphoenix_thread_ready_tracker.sv
// Tracks which threads may be offered to the round-robin issue selector.
// Holds the registered ready mask, its popcount and a sticky protocol error.
module rfphoenix_thread_ready_tracker
    import rfPhoenixPkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NTHREADS-1:0] en,
    input  logic                gnt_v,
    input  Tid                  gnt_tid,
    input  logic                done_v,
    input  Tid                  done_tid,
    input  logic [3:0]          done_dly,
    input  logic                flush_v,
    input  Tid                  flush_tid,
    output logic [NTHREADS-1:0] ready,
    output logic [3:0]          nready,
    output logic                err
);

    thread_state_t       w_st [NTHREADS];
    logic [NTHREADS-1:0] w_nxt_rdy;
    logic [NTHREADS-1:0] r_ready;
    logic [3:0]          r_nready;
    logic                r_err;
    logic                w_gnt_ok;
    logic                w_done_ok;
    logic                w_flush_ok;
    logic                w_bad;

    for (genvar g = 0; g < NTHREADS; g++) begin : g_thr
        rfPhoenix_thread_state u_ts (
            .clk         (clk),
            .rst         (rst),
            .i_en        (en[g]),
            .i_gnt       (gnt_v && gnt_tid == Tid'(g)),
            .i_done      (done_v && done_tid == Tid'(g)),
            .i_dly       (done_dly),
            .i_flush     (flush_v && flush_tid == Tid'(g)),
            .o_state     (w_st[g]),
            .o_nxt_ready (w_nxt_rdy[g])
        );
    end

    // Out-of-range ids match no thread, so they stay "not ok"
    always_comb begin
        w_gnt_ok   = 1'b0;
        w_done_ok  = 1'b0;
        w_flush_ok = 1'b0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (gnt_tid == Tid'(t) && w_st[t] == TS_READY)
                w_gnt_ok = 1'b1;
            if (done_tid == Tid'(t) && w_st[t] == TS_BUSY)
                w_done_ok = 1'b1;
            if (flush_tid == Tid'(t))
                w_flush_ok = 1'b1;
        end
        w_bad = (gnt_v && !w_gnt_ok)
              || (done_v && !w_done_ok)
              || (flush_v && !w_flush_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready  <= '0;
            r_nready <= '0;
            r_err    <= 1'b0;
        end else begin
            r_ready  <= w_nxt_rdy;
            r_nready <= popcnt(w_nxt_rdy);
            r_err    <= r_err | w_bad;
        end
    end

    assign ready  = r_ready;
    assign nready = r_nready;
    assign err    = r_err;

endmodule

// File: tb/tb_rfphoenix_thread_ready_tracker.sv
// Directed bench for the thread ready tracker with hand-computed expectations.
module tb_rfphoenix_thread_ready_tracker;
    import rfPhoenixPkg::*;

    logic                clk;
    logic                rst;
    logic [NTHREADS-1:0] en;
    logic                gnt_v;
    Tid                  gnt_tid;
    logic                done_v;
    Tid                  done_tid;
    logic [3:0]          done_dly;
    logic                flush_v;
    Tid                  flush_tid;
    logic [NTHREADS-1:0] ready;
    logic [3:0]          nready;
    logic                err;

    int checks   = 0;
    int failures = 0;

    rfphoenix_thread_ready_tracker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gnt_v     (gnt_v),
        .gnt_tid   (gnt_tid),
        .done_v    (done_v),
        .done_tid  (done_tid),
        .done_dly  (done_dly),
        .flush_v   (flush_v),
        .flush_tid (flush_tid),
        .ready     (ready),
        .nready    (nready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample #1 after it, and drop single-cycle pulses
    task automatic cyc();
        @(posedge clk);
        #1;
        gnt_v   = 1'b0;
        done_v  = 1'b0;
        flush_v = 1'b0;
    endtask

    task automatic gnt(input int t);
        gnt_v   = 1'b1;
        gnt_tid = Tid'(t);
    endtask

    task automatic done(input int t, input int d);
        done_v   = 1'b1;
        done_tid = Tid'(t);
        done_dly = 4'(d);
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        check(tag, 32'(ready), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; en = '0;
        gnt_v = 0; gnt_tid = '0;
        done_v = 0; done_tid = '0; done_dly = '0;
        flush_v = 0; flush_tid = '0;
        cyc(); cyc();
        check("rst_ready", 32'(ready), 0);
        check("rst_nready", 32'(nready), 0);
        check("rst_err", 32'(err), 0);

        rst = 1'b0; en = 4'b1111;
        cyc();
        chk_rdy("en_all", 4'b1111);
        check("en_nready", 32'(nready), 4);
        check("en_err", 32'(err), 0);

        gnt(2); cyc();
        chk_rdy("gnt2", 4'b1011);
        check("gnt2_nready", 32'(nready), 3);
        done(2, 0); cyc();
        chk_rdy("done2", 4'b1111);

        gnt(1); cyc();
        chk_rdy("gnt1", 4'b1101);
        done(1, 3); cyc();
        chk_rdy("dly3_c1", 4'b1101);
        cyc(); chk_rdy("dly3_c2", 4'b1101);
        cyc(); chk_rdy("dly3_c3", 4'b1101);
        cyc(); chk_rdy("dly3_c4", 4'b1111);
        check("dly3_err", 32'(err), 0);

        gnt(0); cyc();
        done(0, 5); cyc();
        chk_rdy("dly5_enter", 4'b1110);
        cyc(); chk_rdy("dly5_hold", 4'b1110);
        flush_v = 1'b1; flush_tid = Tid'(0); cyc();
        chk_rdy("flush0", 4'b1111);
        gnt(0); cyc();
        done(0, 1); cyc();
        chk_rdy("dly1_c1", 4'b1110);
        cyc(); chk_rdy("dly1_c2", 4'b1111);

        gnt(1); cyc();
        gnt(0); done(1, 0); cyc();
        chk_rdy("same_cyc", 4'b1110);
        check("same_cyc_nready", 32'(nready), 3);
        done(0, 0); cyc();
        chk_rdy("same_cyc_ret", 4'b1111);
        check("same_cyc_err", 32'(err), 0);

        gnt(3); cyc();
        chk_rdy("gnt3a", 4'b0111);
        gnt(3); cyc();
        chk_rdy("gnt3b", 4'b0111);
        check("gnt3b_err", 32'(err), 1);
        cyc();
        check("err_sticky", 32'(err), 1);
        done(3, 0); cyc();
        chk_rdy("busy3_done", 4'b1111);
        check("err_still", 32'(err), 1);

        rst = 1'b1; gnt(1); cyc();
        chk_rdy("rst_mid", 4'b0000);
        check("rst_mid_err", 32'(err), 0);
        rst = 1'b0; cyc();
        chk_rdy("rst_rel", 4'b1111);

        gnt(2); cyc();
        en = 4'b1011; done(2, 0); cyc();
        chk_rdy("dis2", 4'b1011);
        check("dis2_err", 32'(err), 0);
        check("dis2_nready", 32'(nready), 3);
        en = 4'b1111; cyc();
        chk_rdy("reen2", 4'b1111);

        gnt(2); cyc();
        gnt(2); done(2, 0); cyc();
        chk_rdy("gd_busy", 4'b1111);
        check("gd_busy_err", 32'(err), 1);

        rst = 1'b1; cyc();
        rst = 1'b0; cyc();
        gnt(1); done(1, 0); cyc();
        chk_rdy("gd_ready", 4'b1101);
        check("gd_ready_err", 32'(err), 1);

        rst = 1'b1; cyc();
        rst = 1'b0; cyc();
        gnt(5); cyc();
        chk_rdy("oor_tid", 4'b1111);
        check("oor_err", 32'(err), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rfphoenix_thread_ready_tracker.md
RFPHOENIX_THREAD_READY_TRACKER -- requirements
Module: rfPhoenix_thread_ready_tracker

Interface
REQ-001 SHALL have clk, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have en, input, NTHREADS, per-thread enable mask.
REQ-004 SHALL have gnt_v, input, 1, issue grant valid from the round-robin selector.
REQ-005 SHALL have gnt_tid, input, Tid, thread granted issue.
REQ-006 SHALL have done_v, input, 1, pipeline completion valid.
REQ-007 SHALL have done_tid, input, Tid, thread completing.
REQ-008 SHALL have done_dly, input, 4, extra stall cycles before the thread becomes ready again.
REQ-009 SHALL have flush_v / flush_tid, input, 1 / Tid, forced return of one thread to ready.
REQ-010 SHALL have ready, output, NTHREADS, registered ready mask feeding the selector's request input.
REQ-011 SHALL have nready, output, 4, registered count of set bits in ready.
REQ-012 SHALL have err, output, 1, sticky protocol-violation flag.

Function
REQ-013 SHALL hold a per-thread state: DISABLED, READY, BUSY, DELAY, plus a 4-bit delay counter per thread.
REQ-014 DISABLED -> READY when en[t]=1; any state -> DISABLED when en[t]=0 (highest priority, counter cleared).
REQ-015 READY -> BUSY when gnt_v=1 and gnt_tid=t.
REQ-016 BUSY -> READY when done_v=1, done_tid=t, done_dly=0.
REQ-017 BUSY -> DELAY with counter=done_dly when done_v=1, done_tid=t, done_dly!=0.
REQ-018 In DELAY the counter SHALL decrement by 1 per cycle; DELAY -> READY in the cycle the counter is 1 (READY exactly done_dly cycles after the done-induced DELAY entry).
REQ-019 flush_v=1 with flush_tid=t SHALL force BUSY or DELAY -> READY and clear the counter; no effect in DISABLED or READY.
REQ-020 Per-thread priority: en deassert > flush > done > gnt.
REQ-021 Events on different tids in the same cycle SHALL all take effect independently.
REQ-022 ready[t] SHALL be 1 iff next-state of t is READY, registered: a grant drops ready[t] on the next clock edge (1-cycle latency).
REQ-023 nready SHALL equal popcount(ready) in the same cycle (registered together with ready).
REQ-024 err SHALL set on gnt to a thread not READY, done to a thread not BUSY, or any tid >= NTHREADS; err clears only on reset.
REQ-025 An erroneous event SHALL cause no state change for the targeted thread.
REQ-026 gnt and done to the same thread in the same cycle: done applies if BUSY (gnt then flagged err); gnt applies if READY (done flagged err).

Reset
REQ-027 On rst all threads SHALL be DISABLED, counters 0, ready=0, nready=0, err=0.
REQ-028 rst asserted mid-operation SHALL override all events that cycle; first READY can appear the cycle after rst deasserts with en set.

Structure
REQ-029 NTHREADS and Tid SHALL come from rfPhoenixPkg; the thread-state enum (2 bits) SHALL be added to rfPhoenixPkg.
REQ-030 A per-thread sub-module rfPhoenix_thread_state (state + counter) SHALL be instantiated NTHREADS times via generate; popcount and err logic reside in the top.

Verification (NTHREADS=4)
REQ-031 rst then en=4'b1111 -> ready=4'b1111, nready=4 one cycle after; err=0.
REQ-032 gnt_tid=2 -> ready=4'b1011 next cycle; done_tid=2, dly=0 -> ready=4'b1111 next cycle.
REQ-033 gnt_tid=1, then done_tid=1, dly=3 -> ready[1]=0 for 3 cycles after done, 1 on the fourth.
REQ-034 thread 0 in DELAY cnt=5, flush_tid=0 -> ready[0]=1 next cycle, counter 0.
REQ-035 gnt_tid=3 twice back-to-back -> second flagged, err=1 held until rst, thread 3 stays BUSY.
REQ-036 thread 2 BUSY, en[2]=0 with done_tid=2 same cycle -> thread 2 DISABLED, ready[2]=0, err=0; re-enable -> READY.
